// File: rtl/div_iter_pkg.sv
// Shared constants and helpers for the iterative restoring divider.
package div_iter_pkg;

  typedef enum logic [2:0] {
    DIV_FREE   = 3'b000,
    DIV_BYZERO = 3'b001,
    DIV_ON     = 3'b010,
    DIV_FIX    = 3'b011,
    DIV_END    = 3'b100
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  function automatic bit steps_legal(input int steps);
    return (steps == 1) || (steps == 2) || (steps == 4) || (steps == 8);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] part_rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  // The shifted remainder needs one extra bit; the kept result always fits WIDTH
  // because the remainder stays below the divisor.
  logic [WIDTH:0] shifted, diff;

  assign shifted  = {part_rem, dvd_bit};
  assign diff     = shifted - {1'b0, divisor};
  assign q_bit    = ~diff[WIDTH];
  assign next_rem = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_iter.sv
// Multi-cycle restoring divider (signed/unsigned), STEPS quotient bits per clock.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEPS = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               dbz_o,
  output logic               busy_o
);

  localparam int N     = WIDTH / STEPS;
  localparam int CNT_W = $clog2(N + 1);

  if (!steps_legal(STEPS) || (WIDTH % STEPS) != 0 || WIDTH < 8) begin : g_bad_params
    $error("div_iter: illegal WIDTH/STEPS combination");
  end

  div_state_e state, state_n;
  logic [CNT_W-1:0] cnt;
  logic             sgn_q, neg1_q, neg2_q, dbz_q;
  logic [WIDTH-1:0] dvd_q, dvsr_q, rem_q;
  logic [WIDTH-1:0] mag1, mag2;
  logic             accept;

  logic [STEPS:0][WIDTH-1:0] rem_chain;
  logic [STEPS-1:0]          q_bits;

  assign mag1   = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign mag2   = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
  assign accept = (state == DIV_FREE) && (start_i == DivStart) && !annul_i;
  assign busy_o = (state != DIV_FREE);

  // dvd_q doubles as the quotient register: dividend bits leave the top while
  // quotient bits enter the bottom.
  assign rem_chain[0] = rem_q;
  for (genvar s = 0; s < STEPS; s++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .part_rem (rem_chain[s]),
      .dvd_bit  (dvd_q[WIDTH-1-s]),
      .divisor  (dvsr_q),
      .next_rem (rem_chain[s+1]),
      .q_bit    (q_bits[STEPS-1-s])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state <= DIV_FREE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      DIV_FREE:   if (accept) state_n = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
      DIV_BYZERO: state_n = annul_i ? DIV_FREE : DIV_END;
      DIV_ON: begin
        if (annul_i)                       state_n = DIV_FREE;
        else if (cnt == CNT_W'(N - 1))     state_n = DIV_FIX;
      end
      DIV_FIX:    state_n = annul_i ? DIV_FREE : DIV_END;
      DIV_END:    if (start_i == DivStop) state_n = DIV_FREE;
      default:    state_n = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      sgn_q    <= 1'b0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      dbz_q    <= 1'b0;
      dvd_q    <= '0;
      dvsr_q   <= '0;
      rem_q    <= '0;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
      dbz_o    <= 1'b0;
    end else begin
      case (state)
        DIV_FREE: begin
          cnt <= '0;
          if (accept) begin
            sgn_q  <= signed_div_i;
            neg1_q <= signed_div_i & opdata1_i[WIDTH-1];
            neg2_q <= signed_div_i & opdata2_i[WIDTH-1];
            dvd_q  <= mag1;
            dvsr_q <= mag2;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
          end
        end
        DIV_ON: begin
          rem_q <= rem_chain[STEPS];
          dvd_q <= (dvd_q << STEPS) | WIDTH'(q_bits);
          cnt   <= cnt + 1'b1;
        end
        DIV_FIX: begin
          if (sgn_q && (neg1_q ^ neg2_q)) dvd_q <= -dvd_q;
          if (neg1_q)                     rem_q <= -rem_q;
        end
        DIV_BYZERO: begin
          // Negating the latched magnitude recovers the original dividend.
          dvd_q <= '1;
          rem_q <= neg1_q ? -dvd_q : dvd_q;
          dbz_q <= 1'b1;
        end
        DIV_END: begin
          if (start_i == DivStart) begin
            result_o <= {rem_q, dvd_q};
            ready_o  <= DivResultReady;
            dbz_o    <= dbz_q;
          end else begin
            result_o <= '0;
            ready_o  <= DivResultNotReady;
            dbz_o    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: W32/S1, W32/S4 and W64/S8 instances.
module tb_div_iter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]        start, annul, sg;
  logic [2:0][63:0]  op1, op2;
  logic [63:0]       res_a, res_b;
  logic [127:0]      res_c;
  logic [2:0]        rdy, dbz, busy;
  logic [2:0][127:0] res;

  assign res[0] = {64'b0, res_a};
  assign res[1] = {64'b0, res_b};
  assign res[2] = res_c;

  div_iter #(.WIDTH(32), .STEPS(1)) u_a (
    .clk(clk), .rst(rst), .signed_div_i(sg[0]), .opdata1_i(op1[0][31:0]), .opdata2_i(op2[0][31:0]),
    .start_i(start[0]), .annul_i(annul[0]), .result_o(res_a), .ready_o(rdy[0]), .dbz_o(dbz[0]), .busy_o(busy[0]));
  div_iter #(.WIDTH(32), .STEPS(4)) u_b (
    .clk(clk), .rst(rst), .signed_div_i(sg[1]), .opdata1_i(op1[1][31:0]), .opdata2_i(op2[1][31:0]),
    .start_i(start[1]), .annul_i(annul[1]), .result_o(res_b), .ready_o(rdy[1]), .dbz_o(dbz[1]), .busy_o(busy[1]));
  div_iter #(.WIDTH(64), .STEPS(8)) u_c (
    .clk(clk), .rst(rst), .signed_div_i(sg[2]), .opdata1_i(op1[2]), .opdata2_i(op2[2]),
    .start_i(start[2]), .annul_i(annul[2]), .result_o(res_c), .ready_o(rdy[2]), .dbz_o(dbz[2]), .busy_o(busy[2]));

  typedef struct {
    logic [127:0] res;
    logic         dbz;
    int           acc;
    int           lat;
  } exp_t;

  exp_t qa[$], qb[$], qc[$];
  exp_t m_e;
  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;
  logic [2:0] rdy_q = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", nm, got, exp);
  endtask

  // Monitor: every rising ready is matched against the oldest expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rdy[d] && !rdy_q[d]) begin
        logic got_exp;
        got_exp = 1'b1;
        case (d)
          0: if (qa.size() > 0) m_e = qa.pop_front(); else got_exp = 1'b0;
          1: if (qb.size() > 0) m_e = qb.pop_front(); else got_exp = 1'b0;
          default: if (qc.size() > 0) m_e = qc.pop_front(); else got_exp = 1'b0;
        endcase
        if (!got_exp) chk($sformatf("dut%0d_unexpected_ready", d), 128'(rdy[d]), 128'(0));
        else begin
          chk($sformatf("dut%0d_result", d), res[d], m_e.res);
          chk($sformatf("dut%0d_dbz", d), 128'(dbz[d]), 128'(m_e.dbz));
          chk($sformatf("dut%0d_latency", d), 128'(cyc - m_e.acc), 128'(m_e.lat));
        end
      end
    end
    rdy_q = rdy;
  end

  function automatic logic [127:0] rq(input int w, input logic [63:0] r, input logic [63:0] q);
    return (w == 32) ? {64'b0, r[31:0], q[31:0]} : {r, q};
  endfunction

  // Reference: {dbz, remainder, quotient} from the simulator's own arithmetic.
  function automatic logic [128:0] ref_div(input int w, input logic s, input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] m, a, b, q, r;
    longint sa, sb;
    m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    a = a_in & m;
    b = b_in & m;
    if (b == 0) return {1'b1, a, m};
    if (!s) begin
      q = a / b;
      r = a % b;
    end else begin
      if (w == 64) begin sa = $signed(a); sb = $signed(b); end
      else begin sa = $signed(a[31:0]); sb = $signed(b[31:0]); end
      if (w == 64 && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
        q = a;
        r = 64'd0;
      end else begin
        q = 64'(sa / sb);
        r = 64'(sa % sb);
      end
    end
    return {1'b0, r & m, q & m};
  endfunction

  task automatic issue(input int d, input logic s, input logic [63:0] a, input logic [63:0] b,
                       input logic [127:0] er, input logic ed, input int lat);
    exp_t e;
    int t;
    @(negedge clk);
    sg[d] = s; op1[d] = a; op2[d] = b; start[d] = 1'b1;
    e.res = er; e.dbz = ed; e.acc = cyc + 1; e.lat = lat;
    case (d)
      0: qa.push_back(e);
      1: qb.push_back(e);
      default: qc.push_back(e);
    endcase
    // Operands after the accept edge must be ignored.
    @(negedge clk);
    op1[d] = ~a; op2[d] = a ^ b ^ 64'h5A5A_A5A5_0F0F_F0F0; sg[d] = ~s;
    t = 0;
    while (!rdy[d] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!rdy[d]) begin
      n_chk++;
      $display("FAIL dut%0d_timeout ready=0 exp=1", d);
    end
    repeat (2) @(negedge clk);
    chk($sformatf("dut%0d_hold_ready", d), 128'(rdy[d]), 128'(1));
    chk($sformatf("dut%0d_hold_result", d), res[d], er);
    start[d] = 1'b0;
    @(negedge clk);
    chk($sformatf("dut%0d_clr_ready", d), 128'(rdy[d]), 128'(0));
    chk($sformatf("dut%0d_clr_dbz", d), 128'(dbz[d]), 128'(0));
    chk($sformatf("dut%0d_clr_result", d), res[d], 128'(0));
    chk($sformatf("dut%0d_clr_busy", d), 128'(busy[d]), 128'(0));
  endtask

  task automatic issue_ref(input int d, input logic s, input logic [63:0] a, input logic [63:0] b);
    int w, n;
    logic [128:0] x;
    w = (d == 2) ? 64 : 32;
    n = (d == 0) ? 32 : 8;
    x = ref_div(w, s, a, b);
    issue(d, s, a, b, rq(w, x[127:64], x[63:0]), x[128], x[128] ? 2 : n + 2);
  endtask

  task automatic check_idle(input int d, input string tag);
    chk($sformatf("dut%0d_%s_ready", d, tag), 128'(rdy[d]), 128'(0));
    chk($sformatf("dut%0d_%s_dbz", d, tag), 128'(dbz[d]), 128'(0));
    chk($sformatf("dut%0d_%s_result", d, tag), res[d], 128'(0));
    chk($sformatf("dut%0d_%s_busy", d, tag), 128'(busy[d]), 128'(0));
  endtask

  initial begin
    logic [63:0] a, b;
    logic        s;
    rst = 1'b1; start = '0; annul = '0; sg = '0; op1 = '0; op2 = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) check_idle(d, "reset");
    rst = 1'b0;

    // Directed vectors, W=32 S=1 (latency 34, divide-by-zero latency 2).
    issue(0, 1'b0, 64'd100,        64'd7,        rq(32, 64'd2, 64'd14),                 1'b0, 34);
    issue(0, 1'b1, 64'hFFFF_FFF9,  64'd2,        rq(32, 64'hFFFF_FFFF, 64'hFFFF_FFFD),  1'b0, 34);
    issue(0, 1'b1, 64'd7,          64'hFFFF_FFFE, rq(32, 64'd1, 64'hFFFF_FFFD),         1'b0, 34);
    issue(0, 1'b1, 64'h8000_0000,  64'hFFFF_FFFF, rq(32, 64'd0, 64'h8000_0000),         1'b0, 34);
    issue(0, 1'b0, 64'h8000_0000,  64'hFFFF_FFFF, rq(32, 64'h8000_0000, 64'd0),         1'b0, 34);
    issue(0, 1'b0, 64'd5,          64'd0,        rq(32, 64'd5, 64'hFFFF_FFFF),          1'b1, 2);
    issue(0, 1'b1, 64'hFFFF_FFFB,  64'd0,        rq(32, 64'hFFFF_FFFB, 64'hFFFF_FFFF),  1'b1, 2);
    issue(0, 1'b0, 64'hFFFF_FFFF,  64'd1,        rq(32, 64'd0, 64'hFFFF_FFFF),          1'b0, 34);

    // Annul in the 10th ON cycle: no result, then a clean follow-up divide.
    @(negedge clk);
    sg[0] = 1'b0; op1[0] = 64'd12345; op2[0] = 64'd3; start[0] = 1'b1;
    repeat (10) @(negedge clk);
    annul[0] = 1'b1; start[0] = 1'b0;
    @(negedge clk);
    annul[0] = 1'b0;
    chk("dut0_annul_busy", 128'(busy[0]), 128'(0));
    repeat (40) @(negedge clk);
    chk("dut0_annul_ready", 128'(rdy[0]), 128'(0));
    issue(0, 1'b0, 64'd1000, 64'd10, rq(32, 64'd0, 64'd100), 1'b0, 34);

    // W=32 S=4: directed, then mixed operands against the reference model.
    issue(1, 1'b0, 64'd100, 64'd7, rq(32, 64'd2, 64'd14), 1'b0, 10);
    issue_ref(1, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF);
    for (int i = 0; i < 14; i++) begin
      s = i[0];
      a = {$urandom, $urandom};
      b = (i % 3 == 0) ? 64'($urandom_range(1, 20)) : {$urandom, $urandom};
      if (i % 4 == 1) b = -b;
      issue_ref(1, s, a, b);
    end

    // Reset in the middle of ON.
    @(negedge clk);
    sg[1] = 1'b0; op1[1] = 64'd999; op2[1] = 64'd4; start[1] = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1; start[1] = 1'b0;
    @(negedge clk);
    check_idle(1, "midreset");
    rst = 1'b0;
    issue_ref(1, 1'b1, 64'hFFFF_FC18, 64'd7);

    // W=64 S=8.
    issue_ref(2, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    issue_ref(2, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    issue_ref(2, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'd0);
    for (int i = 0; i < 14; i++) begin
      s = ~i[0];
      a = {$urandom, $urandom};
      b = (i % 3 == 0) ? 64'($urandom_range(1, 300)) : {$urandom, $urandom};
      if (i % 4 == 2) b = -b;
      issue_ref(2, s, a, b);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/div_iter.md
# div_iter

Parametrised multi-cycle restoring divider for the EX stage, for DIV/DIVU and their wider-datapath variants. The divider latches both operands on a start handshake and retires STEPS quotient bits per clock. It returns the quotient and remainder on result_o, holds them with ready_o until the requester drops start_i, and reports division by zero explicitly.

## Interface
- WIDTH, 32: operand width; must be ≥8 and divisible by STEPS.
- STEPS, 1: quotient bits resolved per cycle; legal values 1, 2, 4, 8.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- signed_div_i  in  1  1 = signed (two's complement) division, 0 = unsigned.
- opdata1_i  in  WIDTH  dividend; sampled only at the accept edge.
- opdata2_i  in  WIDTH  divisor; sampled only at the accept edge.
- start_i  in  1  request; held high until the result is consumed.
- annul_i  in  1  cancels the operation (pipeline flush).
- result_o  out  2*WIDTH  {remainder, quotient}.
- ready_o  out  1  result_o valid.
- dbz_o  out  1  result is from a zero divisor; valid with ready_o.
- busy_o  out  1  state is not FREE.

## Operation
- States: FREE, BYZERO, ON, FIX, END.
- FREE:
  - Accept when start_i=1 and annul_i=0.
  - Accept latches signed_div_i, the operand signs and both magnitudes. A magnitude is the two's-complement negation when signed and the MSB is 1.
  - Divisor = 0 → BYZERO. Otherwise → ON with cnt=0 and the partial remainder cleared.
- ON: each edge performs STEPS restoring steps in series.
  - Each step shifts the next dividend bit into the partial remainder (WIDTH+1 bits) and subtracts the divisor.
  - Non-negative difference: keep the difference, quotient bit = 1. Negative difference: restore, quotient bit = 0.
  - cnt increments each edge. After WIDTH/STEPS edges → FIX.
- FIX (one edge): operates on the latched signs only; live inputs are ignored.
  - Quotient is negated if signed and the signs differ.
  - Remainder is negated if signed and the dividend was negative; the remainder takes the sign of the dividend.
- BYZERO (one edge): sets quotient = all ones and remainder = the original dividend (not the magnitude), sets the dbz flag → END.
- END:
  - start_i=1: ready_o=1; result_o and dbz_o hold.
  - start_i=0: → FREE; ready_o, dbz_o and result_o cleared on that same edge. This applies to the first END edge too.
- annul_i=1 in BYZERO, ON or FIX → FREE next edge. The result is discarded and ready_o never rises. annul_i is ignored in END.
- Overflow case MIN / −1 (signed) gives quotient = MIN and remainder = 0. This falls out of the magnitude arithmetic and needs no special case.
- Reset: state=FREE, cnt=0; result_o=0, ready_o=0, dbz_o=0, busy_o=0.

## Timing
- Accept at edge E0. ON spans E1..EN, where N = WIDTH/STEPS. FIX at E(N+1). ready_o rises after E(N+2).
- Latency from accept to ready_o = N+2 cycles: 34 for WIDTH=32/STEPS=1, 10 for STEPS=4.
- Divide by zero: accept at E0, BYZERO at E1, ready_o rises after E2.
- ready_o falls one edge after start_i is sampled low in END.
- The earliest new accept is the edge after the return to FREE; there is no back-to-back accept on the dropping edge.
- busy_o is combinational from the state register.
- Operand changes after E0 have no effect on the result.

## Structure
- Shared package constants:
  - DIV_FREE, DIV_BYZERO, DIV_ON, DIV_FIX, DIV_END state encodings (3 bits).
  - DivStart / DivStop, DivResultReady / DivResultNotReady.
- Parameter legality (STEPS set, WIDTH % STEPS) is checked by an elaboration-time assertion.
- cnt width = $clog2(WIDTH/STEPS + 1).
- Sub-module div_step: combinational single restoring step, parametrised by WIDTH.
  - Inputs: partial remainder, next dividend bit, divisor. Outputs: new remainder, quotient bit.
  - The top level instantiates STEPS of these in a generate chain.

## Test plan
- Unsigned, W=32, S=1: 100 / 7 → quotient 14, remainder 2, dbz_o=0; ready_o exactly 34 cycles after accept.
- Signed: −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / −2 → quotient 0xFFFFFFFD, remainder 1.
- 0x80000000 / 0xFFFFFFFF:
  - Signed → quotient 0x80000000, remainder 0.
  - Unsigned → quotient 0, remainder 0x80000000.
- 5 / 0 → quotient 0xFFFFFFFF, remainder 5, dbz_o=1; ready_o after 2 cycles. Drop start_i → all outputs 0 next cycle.
- Annul and operand isolation:
  - annul_i pulsed at the 10th ON cycle → FREE, ready_o stays 0. A following 1000 / 10 returns quotient 100, remainder 0.
  - Changing opdata1_i/opdata2_i after accept does not alter the result.
- STEPS=4, and STEPS=8 with WIDTH=64: randomized signed/unsigned operands vs reference model.
  - Latency N+2.
  - Reset asserted mid-ON → every output 0 and state FREE after the reset edge.
